param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO: next-generation buffering block for the FIFO datapath.
//  Holds up to DEPTH words of DATA_W bits in an internal register array (no external RAM).
//  Supports simultaneous read and write, occupancy count, almost-full/almost-empty
//  thresholds and overflow/underflow error pulses.
//  Sits between a producer and a consumer in the same clk domain.
// PARAMETERS
//  DATA_W     8   width of each stored word (bits)
//  DEPTH      16  number of entries; any integer >= 2 (power of two not required)
//  AF_THRESH  14  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH  2   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
//  Derived: AW = $clog2(DEPTH) pointer width; CW = $clog2(DEPTH+1) count width
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  wr_en         in   1       write request
//  wr_data       in   DATA_W  write word
//  rd_en         in   1       read request (acknowledge in FWFT mode)
//  rd_data       out  DATA_W  read word
//  rd_valid      out  1       rd_data holds a valid word
//  full          out  1       count == DEPTH
//  empty         out  1       count == 0
//  almost_full   out  1       count >= AF_THRESH
//  almost_empty  out  1       count <= AE_THRESH
//  count         out  CW      current occupancy
//  overflow      out  1       1-cycle pulse: wr_en while full
//  underflow     out  1       1-cycle pulse: rd_en while empty
// BEHAVIOUR
//  - Reset (synchronous, active-high, clk): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0.
//    Storage array is not cleared. Reset wins over any concurrent wr_en/rd_en.
//  - Write accepted (wr_acc) iff wr_en && !full; mem[wr_ptr]<=wr_data, wr_ptr advances.
//  - Read accepted (rd_acc) iff rd_en && !empty; rd_ptr advances.
//  - Full blocks writes even if a read is accepted in the same cycle; empty blocks reads
//    even if a write is accepted in the same cycle (no bypass).
//  - Pointer wrap: ptr == DEPTH-1 -> 0 on advance (explicit compare, not modulo-2^AW).
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  - full/empty/almost_* are registered and derived from next-count: valid on the same
//    edge that updates count. No combinational paths from wr_en/rd_en to flags.
//  - overflow <= wr_en && full; underflow <= rd_en && empty; rejected ops change no state.
//  - Standard mode: 1-cycle read latency; on rd_acc at edge N, rd_data = head word and
//    rd_valid=1 after edge N; rd_valid=0 after any edge without rd_acc;
//    rd_data holds last value.
//  - Data order strictly first-in first-out across wrap-around; no word lost or duplicated.
// CONFIGURATION
//  FIFO_FWFT_EN defined: first-word fall-through. rd_data = mem[rd_ptr] (combinational
//    from array), rd_valid = !empty; rd_en acts as acknowledge that pops the head.
//    Word written into an empty FIFO is visible on rd_data the cycle after its write edge.
//    Read latency 0 cycles; flags, count and error pulses identical to standard mode.
//  FIFO_FWFT_EN undefined: standard registered-read mode as above.
// TESTING
//  1 Reset then idle -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0.
//  2 DEPTH=16: write 0x00..0x0F -> full=1, count=16, almost_full from 14th write;
//    17th wr_en -> overflow pulse 1 cycle, count stays 16.
//  3 Drain full FIFO -> rd_data 0x00..0x0F in order, rd_valid one cycle after each rd_en;
//    extra rd_en on empty -> underflow pulse, count=0.
//  4 count=8, wr_en=rd_en=1 for 40 cycles (ptr wraps, incl. DEPTH=10 build)
//    -> count stays 8, output order matches input order.
//  5 Simultaneous wr_en+rd_en when empty -> write accepted, underflow=1, count=1;
//    when full -> read accepted, overflow=1, count=15.
//  6 Assert reset mid-stream with count=5 -> next cycle count=0, empty=1, no rd_valid;
//    FIFO_FWFT_EN build: single write 0xA5 -> rd_data=0xA5, rd_valid=1 next cycle.

Source files
------------

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO built on a register array.
// Define FIFO_FWFT_EN for first-word fall-through reads.
module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              underflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          wr_acc, rd_acc;

  // Wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(
    input logic [AW-1:0] p
  );
    if (p == AW'(DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + AW'(1);
    end
  endfunction

  // Accept decisions see only registered flags: no bypass.
  always_comb begin
    wr_acc = wr_en && !full_q;
    rd_acc = rd_en && !empty_q;
  end

  // Pointer, occupancy, flag and error-pulse next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (rd_acc) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_THRESH));
    aempty_d = (count_d <= CW'(AE_THRESH));
    ovf_d    = wr_en && full_q;
    udf_d    = rd_en && empty_q;
  end

  // Control state; reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array; contents are left alone by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word falls through; rd_en only acknowledges it.
  always_comb begin
    rd_data  = mem_q[rd_ptr_q];
    rd_valid = !empty_q;
  end
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Registered read: head word captured on an accepted read.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_acc;
    if (rd_acc) begin
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  // Read output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Drive read outputs from their registers.
  always_comb begin
    rd_data  = rd_data_q;
    rd_valid = rd_valid_q;
  end
`endif

  // Status outputs are straight from flops.
  always_comb begin
    count        = count_q;
    full         = full_q;
    empty        = empty_q;
    almost_full  = afull_q;
    almost_empty = aempty_q;
    overflow     = ovf_q;
    underflow    = udf_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard bench for param_sync_fifo.
// Covers DEPTH=16 and a DEPTH=10 instance for non power-of-two wrap.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty;
  logic       almost_full, almost_empty;
  logic       overflow, underflow;
  logic [4:0] count;

  logic       w10 = 1'b0;
  logic       r10 = 1'b0;
  logic [7:0] d10 = '0;
  logic [7:0] rd_data10;
  logic       rd_valid10, full10, empty10;
  logic       af10, ae10, ovf10, udf10;
  logic [3:0] count10;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp10_q[$];

  always #5 clk = ~clk;

  param_sync_fifo #(
    .DATA_W(8), .DEPTH(16),
    .AF_THRESH(14), .AE_THRESH(2)
  ) u_dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count), .overflow(overflow),
    .underflow(underflow)
  );

  param_sync_fifo #(
    .DATA_W(8), .DEPTH(10),
    .AF_THRESH(8), .AE_THRESH(2)
  ) u_dut10 (
    .clk(clk), .reset(reset),
    .wr_en(w10), .wr_data(d10),
    .rd_en(r10), .rd_data(rd_data10),
    .rd_valid(rd_valid10), .full(full10),
    .empty(empty10),
    .almost_full(af10),
    .almost_empty(ae10),
    .count(count10), .overflow(ovf10),
    .underflow(udf10)
  );

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Drive one cycle on the DEPTH=16 instance.
  task automatic cyc(
    input logic       w,
    input logic [7:0] d,
    input logic       r,
    input logic       push
  );
    wr_en = w;
    wr_data = d;
    rd_en = r;
    if (push) exp_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Drive one cycle on the DEPTH=10 instance.
  task automatic cyc10(
    input logic       w,
    input logic [7:0] d,
    input logic       r
  );
    w10 = w;
    d10 = d;
    r10 = r;
    if (w) exp10_q.push_back(d);
    @(posedge clk);
    #1;
    w10 = 1'b0;
    r10 = 1'b0;
  endtask

  // Monitor: compare each delivered word with the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
`ifdef FIFO_FWFT_EN
      if (rd_valid && rd_en) begin
`else
      if (rd_valid) begin
`endif
        if (exp_q.size() == 0) begin
          chk("sb16_extra", 32'(rd_data), 32'hxx);
        end else begin
          chk("sb16_data", 32'(rd_data),
              32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Monitor for the DEPTH=10 instance.
  always @(negedge clk) begin
    if (!reset) begin
`ifdef FIFO_FWFT_EN
      if (rd_valid10 && r10) begin
`else
      if (rd_valid10) begin
`endif
        if (exp10_q.size() == 0) begin
          chk("sb10_extra", 32'(rd_data10), 32'hxx);
        end else begin
          chk("sb10_data", 32'(rd_data10),
              32'(exp10_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 8'h00, 0, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rdv", 32'(rd_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);

    // 2: fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1, 8'(i), 0, 1);
      chk("fill_count", 32'(count), i + 1);
      chk("fill_af", 32'(almost_full),
          32'((i + 1) >= 14));
      chk("fill_ae", 32'(almost_empty),
          32'((i + 1) <= 2));
      chk("fill_full", 32'(full), 32'(i == 15));
    end
    cyc(1, 8'hEE, 0, 0);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(0, 8'h00, 0, 0);
    chk("ovf_clear", 32'(overflow), 0);

    // 3: drain, then read on empty
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("drain_count", 32'(count), 15 - i);
      chk("drain_full", 32'(full), 0);
    end
    chk("drain_empty", 32'(empty), 1);
    cyc(0, 8'h00, 0, 0);
    chk("drain_rdv_low", 32'(rd_valid), 0);
    cyc(0, 8'h00, 1, 0);
    chk("udf_pulse", 32'(underflow), 1);
    chk("udf_count", 32'(count), 0);
    cyc(0, 8'h00, 0, 0);
    chk("udf_clear", 32'(underflow), 0);

    // 5a: write+read on empty
    cyc(1, 8'h55, 1, 1);
    chk("we_udf", 32'(underflow), 1);
    chk("we_count", 32'(count), 1);
    chk("we_empty", 32'(empty), 0);
    cyc(0, 8'h00, 1, 0);
    chk("we_drain", 32'(count), 0);

    // 4: count 8, 40 cycles of write+read
    for (int i = 0; i < 8; i++) cyc(1, 8'h10 + 8'(i), 0, 1);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'h18 + 8'(i), 1, 1);
      chk("stream_count", 32'(count), 8);
    end
    for (int i = 0; i < 8; i++) cyc(0, 8'h00, 1, 0);
    chk("stream_empty", 32'(empty), 1);

    // 5b: write+read on full
    for (int i = 0; i < 16; i++) cyc(1, 8'h80 + 8'(i), 0, 1);
    cyc(1, 8'hFF, 1, 0);
    chk("wf_ovf", 32'(overflow), 1);
    chk("wf_count", 32'(count), 15);
    chk("wf_full", 32'(full), 0);
    for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
    chk("wf_empty", 32'(empty), 1);
    cyc(0, 8'h00, 0, 0);

    // 6: reset mid-stream with count 5
    for (int i = 0; i < 5; i++) cyc(1, 8'h30 + 8'(i), 0, 1);
    chk("pre_rst_count", 32'(count), 5);
    reset = 1'b1;
    cyc(1, 8'h99, 1, 0);
    reset = 1'b0;
    exp_q.delete();
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_rdv", 32'(rd_valid), 0);
    cyc(0, 8'h00, 0, 0);
    chk("post_rst_rdv", 32'(rd_valid), 0);

    cyc(1, 8'hA5, 0, 1);
`ifdef FIFO_FWFT_EN
    chk("fwft_data", 32'(rd_data), 32'hA5);
    chk("fwft_rdv", 32'(rd_valid), 1);
    cyc(0, 8'h00, 1, 0);
    chk("fwft_pop_rdv", 32'(rd_valid), 0);
`else
    cyc(0, 8'h00, 1, 0);
    chk("std_data", 32'(rd_data), 32'hA5);
    chk("std_rdv", 32'(rd_valid), 1);
    cyc(0, 8'h00, 0, 0);
    chk("std_rdv_drop", 32'(rd_valid), 0);
    chk("std_data_hold", 32'(rd_data), 32'hA5);
`endif
    chk("a5_count", 32'(count), 0);

    // DEPTH=10: streaming wrap, then full
    for (int i = 0; i < 5; i++) cyc10(1, 8'h40 + 8'(i), 0);
    for (int i = 0; i < 30; i++) begin
      cyc10(1, 8'h50 + 8'(i), 1);
      chk("d10_stream_count", 32'(count10), 5);
    end
    for (int i = 0; i < 5; i++) cyc10(1, 8'hC0 + 8'(i), 0);
    chk("d10_full", 32'(full10), 1);
    chk("d10_count", 32'(count10), 10);
    chk("d10_af", 32'(af10), 1);
    w10 = 1'b1;
    d10 = 8'hEE;
    @(posedge clk);
    #1;
    w10 = 1'b0;
    chk("d10_ovf", 32'(ovf10), 1);
    for (int i = 0; i < 10; i++) cyc10(0, 8'h00, 1);
    chk("d10_empty", 32'(empty10), 1);

    repeat (3) @(posedge clk);
    #1;
    chk("sb16_left", 32'(exp_q.size()), 0);
    chk("sb10_left", 32'(exp10_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
